// File: rtl/event_arbiter.sv
// Round-robin arbiter that captures per-unit class events into single-entry pending slots,
// stamps them with a frame count and serialises them onto one valid/ready event stream.
`timescale 1ns/1ps
module event_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int TS_WIDTH  = 16,
    parameter int OVF_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_UNITS-1:0]         spike_detection_array,
    input  logic [2*NUM_UNITS-1:0]       event_out_array,
    input  logic                         frame_valid,
    input  logic                         arb_enable,
    output logic                         ev_valid,
    input  logic                         ev_ready,
    output logic [$clog2(NUM_UNITS)-1:0] ev_unit,
    output logic [1:0]                   ev_class,
    output logic                         ev_spike,
    output logic [TS_WIDTH-1:0]          ev_timestamp,
    output logic [NUM_UNITS-1:0]         pending,
    output logic [OVF_WIDTH-1:0]         overflow_count
);
    localparam int UW      = $clog2(NUM_UNITS);
    localparam int OVF_MAX = (2 ** OVF_WIDTH) - 1;

    typedef enum logic {IDLE, OFFER} state_t;
    state_t state, next_state;

    logic [TS_WIDTH-1:0]    frame_count;
    logic [2*NUM_UNITS-1:0] prev_code;
    logic [1:0]             slot_class [NUM_UNITS];
    logic                   slot_spike [NUM_UNITS];
    logic [TS_WIDTH-1:0]    slot_ts    [NUM_UNITS];
    logic [UW-1:0]          last_grant;
    logic [UW-1:0]          pick;
    logic [UW-1:0]          idx;
    logic                   found;
    logic                   load;
    logic [NUM_UNITS-1:0]   capture;
    logic [NUM_UNITS-1:0]   grant;
    logic [NUM_UNITS-1:0]   drop;
    int                     drop_total;
    logic [OVF_WIDTH-1:0]   ovf_next;

    // Round-robin search starting one past the most recent grant.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_UNITS; k++) begin
            idx = UW'((int'(last_grant) + k) % NUM_UNITS);
            if (!found && pending[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        load = arb_enable && (|pending) && ((state == IDLE) || ev_ready);
        if (load)
            next_state = OFFER;
        else if ((state == OFFER) && ev_ready)
            next_state = IDLE;
    end

    // A slot being granted this cycle is free to take a new capture; otherwise a busy slot drops it.
    always_comb begin
        capture    = '0;
        grant      = '0;
        drop       = '0;
        drop_total = 0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            capture[i] = (event_out_array[2*i+:2] != 2'b00) &&
                         (event_out_array[2*i+:2] != prev_code[2*i+:2]);
            grant[i]   = load && (pick == UW'(i));
            drop[i]    = capture[i] && pending[i] && !grant[i];
            drop_total = drop_total + (drop[i] ? 1 : 0);
        end
        if (drop_total > (OVF_MAX - int'(overflow_count)))
            ovf_next = '1;
        else
            ovf_next = overflow_count + OVF_WIDTH'(drop_total);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    assign ev_valid = (state == OFFER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_unit      <= '0;
            ev_class     <= '0;
            ev_spike     <= 1'b0;
            ev_timestamp <= '0;
            last_grant   <= UW'(NUM_UNITS - 1);
        end else if (load) begin
            ev_unit      <= pick;
            ev_class     <= slot_class[pick];
            ev_spike     <= slot_spike[pick];
            ev_timestamp <= slot_ts[pick];
            last_grant   <= pick;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count    <= '0;
            prev_code      <= '0;
            pending        <= '0;
            overflow_count <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                slot_class[i] <= '0;
                slot_spike[i] <= 1'b0;
                slot_ts[i]    <= '0;
            end
        end else begin
            prev_code      <= event_out_array;
            overflow_count <= ovf_next;
            if (frame_valid)
                frame_count <= frame_count + TS_WIDTH'(1);
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (capture[i] && (!pending[i] || grant[i])) begin
                    slot_class[i] <= event_out_array[2*i+:2];
                    slot_spike[i] <= spike_detection_array[i];
                    slot_ts[i]    <= frame_count;
                    pending[i]    <= 1'b1;
                end else if (grant[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end
endmodule
